// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  localparam int DEF_CODE_W = 5;
  localparam int BLANK_CODE = 0;

endpackage

// File: rtl/display_scan_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module display_scan_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan controller: double-buffered digit codes, blank/show sequencing.
// Optional DISPLAY_LEADING_ZERO_BLANK_EN keeps leading zero digits dark.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int CODE_W       = DEF_CODE_W,
  parameter  int SHOW_CYCLES  = 1000,
  parameter  int BLANK_CYCLES = 8,
  localparam int IW           = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IW-1:0]         wr_digit,
  input  logic [CODE_W-1:0]     wr_code,
  input  logic                  commit,
  output logic                  wr_err,
  output logic [CODE_W-1:0]     code_out,
  output logic [NUM_DIGITS-1:0] digit_en_n,
  output logic                  frame_start
);

  localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ?
                        SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SHOW_LEN  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LEN =
    CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam state_t        ENTRY     =
    (BLANK_CYCLES > 0) ? BLANK : SHOW;
  localparam logic [CW-1:0] ENTRY_LEN =
    (BLANK_CYCLES > 0) ? BLANK_LEN : SHOW_LEN;
  localparam logic [IW-1:0] LAST      = IW'(NUM_DIGITS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         w_idx_nxt;
  logic [CODE_W-1:0]     r_shadow  [NUM_DIGITS];
  logic [CODE_W-1:0]     r_active  [NUM_DIGITS];
  logic [CODE_W-1:0]     w_act_nxt [NUM_DIGITS];
  logic                  r_pending;
  logic                  r_fs;
  logic                  r_err;
  logic [CODE_W-1:0]     r_code;
  logic [NUM_DIGITS-1:0] r_en_n;
  logic                  w_xfer;
  logic                  w_wrap;
  logic                  w_load;
  logic [CW-1:0]         w_load_val;
  logic                  w_done;
  logic                  w_accept;
  logic                  w_in_range;
  logic [NUM_DIGITS-1:0] w_lit;
  logic [NUM_DIGITS-1:0] w_en_nxt;
  logic [CODE_W-1:0]     w_code_nxt;

  display_scan_timer #(
    .W (CW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_done (w_done)
  );

  assign wr_ready    = ~r_pending;
  assign w_accept    = wr_valid & ~r_pending;
  assign w_in_range  = (int'(wr_digit) < NUM_DIGITS);
  assign w_xfer      = r_pending &
                       ((r_state == IDLE) | (enable & w_wrap));
  assign wr_err      = r_err;
  assign code_out    = r_code;
  assign digit_en_n  = r_en_n;
  assign frame_start = r_fs;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_load_val  = ENTRY_LEN;
    w_wrap      = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = ENTRY;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
        end
        BLANK: begin
          if (w_done) begin
            w_state_nxt = SHOW;
            w_load      = 1'b1;
            w_load_val  = SHOW_LEN;
          end
        end
        SHOW: begin
          if (w_done) begin
            w_wrap      = (r_idx == LAST);
            w_idx_nxt   = w_wrap ? '0 : r_idx + 1'b1;
            w_state_nxt = ENTRY;
            w_load      = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are computed from the buffer contents in force next cycle.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_act_nxt[i] = w_xfer ? r_shadow[i] : r_active[i];
    end
  end

  always_comb begin
    w_lit = '1;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    begin
      logic v_any;
      v_any = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
        v_any    = v_any | (w_act_nxt[i] != '0);
        w_lit[i] = v_any | (i == 0);
      end
    end
`endif
  end

  always_comb begin
    w_code_nxt = CODE_W'(BLANK_CODE);
    w_en_nxt   = '1;
    if (w_state_nxt != IDLE) begin
      w_code_nxt = w_act_nxt[w_idx_nxt];
    end
    if (w_state_nxt == SHOW && w_lit[w_idx_nxt]) begin
      w_en_nxt[w_idx_nxt] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_fs      <= 1'b0;
      r_err     <= 1'b0;
      r_code    <= '0;
      r_en_n    <= '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_code  <= w_code_nxt;
      r_en_n  <= w_en_nxt;
      r_fs    <= w_xfer;
      r_err   <= w_accept & ~w_in_range;
      if (w_xfer) begin
        r_pending <= 1'b0;
      end else if (commit) begin
        r_pending <= 1'b1;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_xfer) begin
          r_active[i] <= r_shadow[i];
        end
      end
      if (w_accept && w_in_range) begin
        r_shadow[wr_digit] <= wr_code;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench: frame-position reference model plus directed checks.
module tb_display_scan_ctrl;

  localparam int N     = 4;
  localparam int S     = 4;
  localparam int B     = 2;
  localparam int P     = B + S;
  localparam int FRAME = N * P;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, wr_valid, commit;
  logic [1:0] wr_digit;
  logic [4:0] wr_code;
  logic       wr_ready, wr_err, frame_start;
  logic [4:0] code_out;
  logic [3:0] digit_en_n;

  logic       e3, v3, cm3;
  logic [1:0] d3;
  logic [4:0] c3;
  logic       rdy3, err3, fs3;
  logic [4:0] co3;
  logic [2:0] en3;

  int n_chk = 0;
  int n_err = 0;
  int cur;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS(N), .CODE_W(5), .SHOW_CYCLES(S), .BLANK_CYCLES(B)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_digit(wr_digit), .wr_code(wr_code), .commit(commit),
    .wr_err(wr_err), .code_out(code_out),
    .digit_en_n(digit_en_n), .frame_start(frame_start)
  );

  display_scan_ctrl #(
    .NUM_DIGITS(3), .CODE_W(5), .SHOW_CYCLES(2), .BLANK_CYCLES(0)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .enable(e3),
    .wr_valid(v3), .wr_ready(rdy3),
    .wr_digit(d3), .wr_code(c3), .commit(cm3),
    .wr_err(err3), .code_out(co3),
    .digit_en_n(en3), .frame_start(fs3)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: scan position is a plain cycle count within a frame.
  bit         m_scan, m_pend, m_err, m_fs;
  int         m_t;
  logic [4:0] m_sh [N];
  logic [4:0] m_ac [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_scan = 0; m_pend = 0; m_err = 0; m_fs = 0; m_t = 0;
      for (int i = 0; i < N; i++) begin
        m_sh[i] = '0;
        m_ac[i] = '0;
      end
    end else begin
      bit xfer;
      xfer  = m_pend && (!m_scan || (enable && m_t == FRAME - 1));
      m_err = 0;
      if (wr_valid && !m_pend) begin
        if (int'(wr_digit) < N) m_sh[wr_digit] = wr_code;
        else m_err = 1;
      end
      if (xfer) begin
        for (int i = 0; i < N; i++) m_ac[i] = m_sh[i];
      end
      m_fs = xfer;
      if (xfer) m_pend = 0;
      else if (commit) m_pend = 1;
      if (!enable) begin
        m_scan = 0; m_t = 0;
      end else if (!m_scan) begin
        m_scan = 1; m_t = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
    end
  end

  function automatic bit lit(input int k);
    if (!LZB || k == 0) return 1'b1;
    for (int j = k; j < N; j++) if (m_ac[j] != 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      int ec, slot, ph;
      logic [N-1:0] ee;
      ec = 0;
      ee = '1;
      if (m_scan) begin
        slot = m_t / P;
        ph   = m_t % P;
        ec   = int'(m_ac[slot]);
        if (ph >= B && lit(slot)) ee[slot] = 1'b0;
      end
      chk("model_code_out", int'(code_out), ec);
      chk("model_digit_en_n", int'(digit_en_n), int'(ee));
      chk("model_wr_ready", int'(wr_ready), int'(!m_pend));
      chk("model_wr_err", int'(wr_err), int'(m_err));
      chk("model_frame_start", int'(frame_start), int'(m_fs));
    end
  end

  task automatic wr(input int d, input int c, input bit cm);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_digit = 2'(d);
    wr_code  = 5'(c);
    commit   = cm;
    @(negedge clk);
    wr_valid = 1'b0;
    commit   = 1'b0;
  endtask

  task automatic wait_fs(input string name);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_start) begin ok = 1; break; end
    end
    chk(name, int'(ok), 1);
    cur = 0;
  endtask

  task automatic wait_en(input logic [3:0] p, input string name);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (digit_en_n == p) begin ok = 1; break; end
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic wait_ready(input string name);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_ready) begin ok = 1; break; end
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic at(input int o);
    while (cur < o) begin
      @(negedge clk);
      cur++;
    end
  endtask

  initial begin
    rst_n = 0; enable = 0; wr_valid = 0; commit = 0;
    wr_digit = 0; wr_code = 0;
    e3 = 0; v3 = 0; cm3 = 0; d3 = 0; c3 = 0;
    repeat (3) @(negedge clk);
    chk("rst_en", int'(digit_en_n), 'hF);
    chk("rst_code", int'(code_out), 0);
    chk("rst_ready", int'(wr_ready), 1);
    chk("rst_err", int'(wr_err), 0);
    chk("rst_fs", int'(frame_start), 0);
    rst_n = 1;

    @(negedge clk);
    enable = 1;
    wr(0, 3, 0); wr(1, 7, 0); wr(2, 31, 0); wr(3, 0, 1);
    wait_fs("fs_first_commit");
    chk("f0_code", int'(code_out), 3);
    chk("f0_en", int'(digit_en_n), 'hF);
    at(2);  chk("f2_en", int'(digit_en_n), 'hE);
    chk("f2_code", int'(code_out), 3);
    at(6);  chk("f6_code", int'(code_out), 7);
    chk("f6_en", int'(digit_en_n), 'hF);
    at(8);  chk("f8_en", int'(digit_en_n), 'hD);
    at(14); chk("f14_code", int'(code_out), 31);
    chk("f14_en", int'(digit_en_n), 'hB);
    at(20); chk("f20_code", int'(code_out), 0);
    chk("f20_en", int'(digit_en_n), LZB ? 'hF : 'h7);
    at(24); chk("f24_code", int'(code_out), 3);
    chk("f24_en", int'(digit_en_n), 'hF);
    chk("f24_fs", int'(frame_start), 0);

    wait_en(4'b1101, "wait_d1");
    commit = 1;
    @(negedge clk);
    commit = 0;
    chk("ready_low", int'(wr_ready), 0);
    wr_valid = 1; wr_digit = 2; wr_code = 9;
    wait_ready("ready_return");
    chk("ready_at_fs", int'(frame_start), 1);
    @(negedge clk);
    wr_valid = 0;

    wait_en(4'b1011, "wait_d2");
    enable = 0;
    @(negedge clk);
    chk("dis_en", int'(digit_en_n), 'hF);
    chk("dis_code", int'(code_out), 0);
    enable = 1;
    @(negedge clk);
    chk("reen_blank", int'(digit_en_n), 'hF);
    repeat (2) @(negedge clk);
    chk("reen_d0", int'(digit_en_n), 'hE);
    chk("reen_code", int'(code_out), 3);

    wr(3, 0, 0); wr(2, 0, 0); wr(1, 5, 0); wr(0, 0, 1);
    wait_fs("fs_lzb");
    at(2);  chk("lz_d0", int'(digit_en_n), 'hE);
    at(8);  chk("lz_d1", int'(digit_en_n), 'hD);
    chk("lz_d1_code", int'(code_out), 5);
    at(14); chk("lz_d2", int'(digit_en_n), LZB ? 'hF : 'hB);
    at(20); chk("lz_d3", int'(digit_en_n), LZB ? 'hF : 'h7);
    wr(1, 0, 1);
    wait_fs("fs_zero");
    at(2);  chk("z_d0", int'(digit_en_n), 'hE);
    at(8);  chk("z_d1", int'(digit_en_n), LZB ? 'hF : 'hD);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      enable   = ($urandom_range(0, 99) < 98);
      wr_valid = 1'($urandom_range(0, 1));
      wr_digit = 2'($urandom_range(0, 3));
      wr_code  = ($urandom_range(0, 3) == 0) ? 5'd0 :
                 5'($urandom_range(0, 31));
      commit   = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    enable = 1; wr_valid = 0; commit = 0;

    wait_ready("ready_before_rst");
    wr(0, 1, 0); wr(1, 2, 0); wr(2, 3, 0); wr(3, 4, 1);
    wait_fs("fs_before_rst");
    wait_en(4'b1011, "wait_d2_rst");
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_en", int'(digit_en_n), 'hF);
    chk("async_code", int'(code_out), 0);
    chk("async_ready", int'(wr_ready), 1);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_d0", int'(digit_en_n), 'hE);
    chk("post_rst_code", int'(code_out), 0);

    @(negedge clk);
    v3 = 1; d3 = 0; c3 = 1;
    @(negedge clk);
    d3 = 1; c3 = 2;
    @(negedge clk);
    d3 = 2; c3 = 3;
    @(negedge clk);
    chk("n3_err_low", int'(err3), 0);
    d3 = 3; c3 = 9;
    @(negedge clk);
    v3 = 0;
    chk("n3_err_pulse", int'(err3), 1);
    chk("n3_ready", int'(rdy3), 1);
    @(negedge clk);
    chk("n3_err_clear", int'(err3), 0);
    cm3 = 1;
    @(negedge clk);
    cm3 = 0;
    chk("n3_pending", int'(rdy3), 0);
    @(negedge clk);
    chk("n3_fs_idle", int'(fs3), 1);
    chk("n3_ready_back", int'(rdy3), 1);
    e3 = 1;
    @(negedge clk);
    chk("n3_d0_code", int'(co3), 1);
    chk("n3_d0_en", int'(en3), 'h6);
    @(negedge clk);
    chk("n3_d0_hold", int'(en3), 'h6);
    @(negedge clk);
    chk("n3_d1_code", int'(co3), 2);
    chk("n3_d1_en", int'(en3), 'h5);
    repeat (2) @(negedge clk);
    chk("n3_d2_code", int'(co3), 3);
    chk("n3_d2_en", int'(en3), 'h3);
    repeat (2) @(negedge clk);
    chk("n3_wrap_code", int'(co3), 1);
    chk("n3_wrap_en", int'(en3), 'h6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
